// File: rtl/reg_select_sequencer_if.sv
// rtl/reg_select_sequencer_if.sv - handshake/bus bundle for reg_select_sequencer (optional BAOUT_R0_ZERO_EN adds baseZero)
interface reg_select_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] irIn;
  logic [1:0]            mode;
  logic                  start;
  logic                  hold;
  logic [IDX_WIDTH-1:0]  regSel;
  logic                  readEn;
  logic                  writeEn;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] cSignExt;
`ifdef BAOUT_R0_ZERO_EN
  logic                  baseZero;

  modport master (output irIn, mode, start, hold,
                  input  regSel, readEn, writeEn, busy, done, cSignExt, baseZero);
  modport slave  (input  irIn, mode, start, hold,
                  output regSel, readEn, writeEn, busy, done, cSignExt, baseZero);
`else
  modport master (output irIn, mode, start, hold,
                  input  regSel, readEn, writeEn, busy, done, cSignExt);
  modport slave  (input  irIn, mode, start, hold,
                  output regSel, readEn, writeEn, busy, done, cSignExt);
`endif
endinterface

// File: rtl/reg_select_sequencer.sv
// rtl/reg_select_sequencer.sv - steps register-operand phases of one instruction (optional BAOUT_R0_ZERO_EN)
module reg_select_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int C_WIDTH    = 19,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  reg_select_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    RD_C = 3'd3,
    WR_A = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] ir, ir_n;
  logic [1:0]            mode_r, mode_n;
  logic                  accept;
  logic [IDX_WIDTH-1:0]  sel_r, sel_n;
  logic                  rd_r, wr_r, busy_r, done_r;
`ifdef BAOUT_R0_ZERO_EN
  logic                  bz_r;
`endif

  // Every mode except 0 begins by reading Rb.
  function automatic state_t first_phase(input logic [1:0] m);
    return (m == 2'd0) ? WR_A : RD_B;
  endfunction

  // Start acceptance, latch source and next-phase selection.
  always_comb begin
    accept  = (state == IDLE || state == DONE) && bus.start && !bus.hold;
    ir_n    = accept ? bus.irIn : ir;
    mode_n  = accept ? bus.mode : mode_r;
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = first_phase(bus.mode);
      DONE:    state_n = accept ? first_phase(bus.mode) : IDLE;
      RD_B: begin
        case (mode_r)
          2'd2:    state_n = RD_C;
          2'd3:    state_n = RD_A;
          default: state_n = WR_A;
        endcase
      end
      RD_C:    state_n = WR_A;
      RD_A:    state_n = DONE;
      WR_A:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Register index for the phase being entered; idle phases keep the last index.
  always_comb begin
    sel_n = sel_r;
    case (state_n)
      RD_A, WR_A: sel_n = ir_n[26:23];
      RD_B:       sel_n = ir_n[22:19];
      RD_C:       sel_n = ir_n[18:15];
      default:    sel_n = sel_r;
    endcase
  end

  // State, IR latch and registered phase outputs; hold freezes everything.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      ir     <= '0;
      mode_r <= 2'd0;
      sel_r  <= '0;
      rd_r   <= 1'b0;
      wr_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef BAOUT_R0_ZERO_EN
      bz_r   <= 1'b0;
`endif
    end else if (!bus.hold) begin
      state  <= state_n;
      ir     <= ir_n;
      mode_r <= mode_n;
      sel_r  <= sel_n;
      rd_r   <= (state_n == RD_A) || (state_n == RD_B) || (state_n == RD_C);
      wr_r   <= (state_n == WR_A);
      busy_r <= (state_n == RD_A) || (state_n == RD_B) ||
                (state_n == RD_C) || (state_n == WR_A);
      done_r <= (state_n == DONE);
`ifdef BAOUT_R0_ZERO_EN
      bz_r   <= (state_n == RD_B) && (ir_n[22:19] == 4'd0) &&
                ((mode_n == 2'd1) || (mode_n == 2'd3));
`endif
    end
  end

  assign bus.regSel   = sel_r;
  assign bus.readEn   = rd_r;
  assign bus.writeEn  = wr_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.cSignExt = {{(DATA_WIDTH-C_WIDTH){ir[C_WIDTH-1]}}, ir[C_WIDTH-1:0]};
`ifdef BAOUT_R0_ZERO_EN
  assign bus.baseZero = bz_r;
`endif

endmodule

// File: tb/tb_reg_select_sequencer.sv
// tb/tb_reg_select_sequencer.sv - self-checking bench for reg_select_sequencer (optional BAOUT_R0_ZERO_EN)
module tb_reg_select_sequencer;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  reg_select_sequencer_if #(.DATA_WIDTH(32), .IDX_WIDTH(4)) bus();

  reg_select_sequencer #(.DATA_WIDTH(32), .C_WIDTH(19), .IDX_WIDTH(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] sel;
    logic       rd;
    logic       wr;
    logic       bz;
  } ph_t;

  ph_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] sext_c(input logic [31:0] ir);
    logic [31:0] c;
    c = ir & 32'h0007_FFFF;
    return (c >= 32'h0004_0000) ? c + 32'hFFF8_0000 : c;
  endfunction

  // Phase list straight from the mode table: which field, read or write.
  function automatic void build(input logic [31:0] ir, input logic [1:0] m);
    logic [3:0] ra, rb, rc;
    logic       bz;
    ra = 4'((ir >> 23) & 32'hF);
    rb = 4'((ir >> 19) & 32'hF);
    rc = 4'((ir >> 15) & 32'hF);
    bz = (rb == 4'd0) && (m == 2'd1 || m == 2'd3);
    exp_q.delete();
    case (m)
      2'd0: exp_q.push_back('{ra, 1'b0, 1'b1, 1'b0});
      2'd1: begin
        exp_q.push_back('{rb, 1'b1, 1'b0, bz});
        exp_q.push_back('{ra, 1'b0, 1'b1, 1'b0});
      end
      2'd2: begin
        exp_q.push_back('{rb, 1'b1, 1'b0, 1'b0});
        exp_q.push_back('{rc, 1'b1, 1'b0, 1'b0});
        exp_q.push_back('{ra, 1'b0, 1'b1, 1'b0});
      end
      default: begin
        exp_q.push_back('{rb, 1'b1, 1'b0, bz});
        exp_q.push_back('{ra, 1'b1, 1'b0, 1'b0});
      end
    endcase
  endfunction

  task automatic chk_phase(input string tag, input ph_t p, input logic [31:0] c);
    chk({tag, ".regSel"}, 32'(bus.regSel), 32'(p.sel));
    chk({tag, ".readEn"}, 32'(bus.readEn), 32'(p.rd));
    chk({tag, ".writeEn"}, 32'(bus.writeEn), 32'(p.wr));
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".done"}, 32'(bus.done), 32'd0);
    chk({tag, ".cSignExt"}, bus.cSignExt, c);
`ifdef BAOUT_R0_ZERO_EN
    chk({tag, ".baseZero"}, 32'(bus.baseZero), 32'(p.bz));
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".regSel"}, 32'(bus.regSel), 32'd0);
    chk({tag, ".readEn"}, 32'(bus.readEn), 32'd0);
    chk({tag, ".writeEn"}, 32'(bus.writeEn), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'd0);
    chk({tag, ".cSignExt"}, bus.cSignExt, 32'd0);
`ifdef BAOUT_R0_ZERO_EN
    chk({tag, ".baseZero"}, 32'(bus.baseZero), 32'd0);
`endif
  endtask

  // One full sequence from an idle start; optional hold burst at phase hold_at.
  task automatic run_seq(input string tag, input logic [31:0] ir, input logic [1:0] m,
                         input int hold_at, input int hold_len);
    logic [31:0] c;
    int          cyc;
    int          n;
    c = sext_c(ir);
    build(ir, m);
    n = exp_q.size();
    bus.irIn  = ir;
    bus.mode  = m;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.irIn  = $urandom;
    bus.mode  = 2'($urandom_range(0, 3));
    cyc = 1;
    for (int i = 0; i < n; i++) begin
      chk_phase($sformatf("%s.ph%0d", tag, i), exp_q[i], c);
      if (i == hold_at) begin
        bus.hold = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          step();
          cyc++;
          chk_phase($sformatf("%s.hold%0d", tag, h), exp_q[i], c);
        end
        bus.hold = 1'b0;
      end
      step();
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(n + 1 + ((hold_at >= 0) ? hold_len : 0)));
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".done_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done_rd"}, 32'(bus.readEn), 32'd0);
    chk({tag, ".done_wr"}, 32'(bus.writeEn), 32'd0);
    chk({tag, ".done_sel"}, 32'(bus.regSel), 32'(exp_q[n-1].sel));
    chk({tag, ".done_c"}, bus.cSignExt, c);
    step();
    chk({tag, ".idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir_a, ir_b;
    bus.irIn  = '0;
    bus.mode  = 2'd0;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    #1;
    chk_all_zero("reset");
    #11;
    clear = 1'b1;
    step();
    chk_all_zero("idle");

    // Ra=5, Rb=3, Rc=5, mode 2: expects (3,rd) (5,rd) (5,wr) then done at N+4
    run_seq("m2", 32'h029A_8000, 2'd2, -1, 0);
    run_seq("m2_spec_word", 32'h0A9A_8000, 2'd2, -1, 0);

    // Mode 1 with a 3-cycle hold in RD_B
    run_seq("m1_hold", 32'h0123_4567, 2'd1, 0, 3);
    run_seq("m0", 32'h0780_0000, 2'd0, -1, 0);
    run_seq("m3", 32'h0456_0000, 2'd3, -1, 0);

    // Immediate sign extension boundaries
    run_seq("c_neg", 32'h0004_0000, 2'd0, -1, 0);
    chk("c_neg_hex", bus.cSignExt, 32'hFFFC_0000);
    run_seq("c_pos", 32'h0003_FFFF, 2'd0, -1, 0);
    chk("c_pos_hex", bus.cSignExt, 32'h0003_FFFF);

    // Back-to-back: start held through a mode-0 sequence
    ir_a = 32'h0280_0000;
    ir_b = 32'h0500_0000;
    bus.irIn  = ir_a;
    bus.mode  = 2'd0;
    bus.start = 1'b1;
    step();
    chk("b2b.wr1", 32'(bus.writeEn), 32'd1);
    chk("b2b.sel1", 32'(bus.regSel), 32'd5);
    bus.irIn = ir_b;
    step();
    chk("b2b.done1", 32'(bus.done), 32'd1);
    chk("b2b.c_kept", bus.cSignExt, sext_c(ir_a));
    step();
    bus.start = 1'b0;
    chk("b2b.wr2", 32'(bus.writeEn), 32'd1);
    chk("b2b.sel2", 32'(bus.regSel), 32'd10);
    chk("b2b.done_gone", 32'(bus.done), 32'd0);
    step();
    chk("b2b.done2", 32'(bus.done), 32'd1);
    step();
    chk("b2b.idle", 32'(bus.busy), 32'd0);

    // Start while busy is ignored and not queued
    ir_a = 32'h0162_8000;
    build(ir_a, 2'd2);
    bus.irIn  = ir_a;
    bus.mode  = 2'd2;
    bus.start = 1'b1;
    step();
    chk_phase("ign.ph0", exp_q[0], sext_c(ir_a));
    bus.irIn = 32'h07FF_FFFF;
    bus.mode = 2'd0;
    step();
    bus.start = 1'b0;
    chk_phase("ign.ph1", exp_q[1], sext_c(ir_a));
    step();
    chk_phase("ign.ph2", exp_q[2], sext_c(ir_a));
    step();
    chk("ign.done", 32'(bus.done), 32'd1);
    step();
    chk("ign.not_queued", 32'(bus.busy), 32'd0);
    step();
    chk("ign.still_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of RD_C
    bus.irIn  = 32'h0FFF_FFFF;
    bus.mode  = 2'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("rst.in_rdc", 32'(bus.readEn), 32'd1);
    #2;
    clear = 1'b0;
    #1;
    chk_all_zero("rst.async");
    step();
    chk_all_zero("rst.held");
    clear = 1'b1;
    step();
    chk_all_zero("rst.released");
    run_seq("rst.restart", 32'h0123_4567, 2'd2, -1, 0);

`ifdef BAOUT_R0_ZERO_EN
    run_seq("bz_m3", 32'h0280_0000, 2'd3, -1, 0);
    run_seq("bz_m1", 32'h0280_0000, 2'd1, -1, 0);
    run_seq("bz_m2", 32'h0280_0000, 2'd2, -1, 0);
`endif

    // Randomized sequences, some with hold bursts
    for (int k = 0; k < 40; k++) begin
      logic [31:0] r_ir;
      logic [1:0]  r_m;
      int          h_at, h_len;
      r_ir = $urandom;
      if ($urandom_range(0, 3) == 0) r_ir = r_ir & 32'hFF87_FFFF;
      r_m  = 2'($urandom_range(0, 3));
      build(r_ir, r_m);
      h_at  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
      h_len = int'($urandom_range(1, 4));
      run_seq($sformatf("rnd%0d", k), r_ir, r_m, h_at, h_len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_select_sequencer.md
Name: reg_select_sequencer

Overview:
- Upstream neighbour of the 4-to-16 register-select decoder in the datapath.
- Latches a 32-bit instruction word and steps through the register-operand phases of one instruction: read Rb, read Rc, write Ra, or a store-style Ra/Rb read pair.
- Each phase emits a 4-bit register index (feeds the decoder input directly) plus a one-cycle read or write strobe.
- Also supplies the sign-extended C constant to the bus.

Parameters:
- DATA_WIDTH, 32, instruction and constant width.
- C_WIDTH, 19, width of immediate field C (IR[C_WIDTH-1:0]).
- IDX_WIDTH, 4, register index width; fixed by the 16-register file.

Ports:
- clock  input  1  single clock, rising edge.
- clear  input  1  reset, asynchronous, active-low.
- irIn  input  DATA_WIDTH  instruction word; sampled on accepted start.
- mode  input  2  phase program; sampled on accepted start.
- start  input  1  request to begin a sequence.
- hold  input  1  stall; freezes state and all outputs.
- regSel  output  IDX_WIDTH  register index to decoder.
- readEn  output  1  current phase is a register read.
- writeEn  output  1  current phase is a register write.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.
- cSignExt  output  DATA_WIDTH  latched IR[C_WIDTH-1:0] sign-extended from bit C_WIDTH-1.

Behaviour:
- IR field map: Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- States: IDLE, RD_A, RD_B, RD_C, WR_A, DONE.
- Reset (clear low, any time, including mid-sequence): state to IDLE; IR register cleared; regSel=0, readEn=0, writeEn=0, busy=0, done=0, cSignExt=0. No pending request survives reset.
- Start acceptance: start is accepted only in IDLE or DONE with hold=0. On acceptance, irIn and mode are latched and the first phase is entered on the next edge. start in any other state is ignored and not queued.
- Phase sequence by mode, one cycle per phase:
  - 0: WR_A.
  - 1: RD_B, WR_A.
  - 2: RD_B, RD_C, WR_A.
  - 3: RD_B, RD_A (store: base, then data).
  - The last phase goes to DONE.
- Outputs are registered and valid in the phase state:
  - RD_x: regSel = field x, readEn=1.
  - WR_A: regSel = Ra, writeEn=1.
  - Otherwise: regSel holds its last value, strobes are 0.
- busy=1 in RD_A/RD_B/RD_C/WR_A, and 0 in IDLE and DONE.
- done=1 for exactly one cycle in DONE. DONE goes to IDLE, or to the first phase if start is accepted in that cycle (back-to-back, no bubble).
- Latency: start accepted at edge N; mode 2 gives RD_B at N+1, RD_C at N+2, WR_A at N+3, done at N+4.
- hold=1: state, regSel, strobes, done and the IR latch are all frozen. A strobe held high during hold represents the same single access and must not be counted twice.
- readEn and writeEn are never asserted together.
- cSignExt is derived from the latched IR only; it is stable from the cycle after acceptance until the next acceptance.

Optional Feature:
- Macro: BAOUT_R0_ZERO_EN.
- Enabled:
  - Adds output baseZero (1 bit, reset 0).
  - baseZero is asserted together with readEn in RD_B only when Rb=0 and mode is 1 or 3; the register file then drives zero instead of R0.
  - readEn remains asserted.
- Disabled: the port is absent; R0 is treated like any other register.

Test Plan:
- Reset/idle: clear low mid-RD_C (mode 2) -> next observed cycle all outputs 0, state IDLE; start after release restarts cleanly.
- Mode 2 with irIn=32'h0A9A_8000 (Ra=5, Rb=3, Rc=5): expected sequence of (regSel, readEn, writeEn) is (3,1,0), (5,1,0), (5,0,1), then done=1 for one cycle.
- Hold: mode 1 with hold=1 for 3 cycles during RD_B -> regSel=Rb and readEn=1 for 4 cycles; WR_A follows; done asserts 3 cycles later than the no-hold run.
- Back-to-back and ignored start: start held high through a mode-0 sequence -> second sequence starts in the cycle after DONE; starts during busy are ignored.
- cSignExt: IR[18:0]=19'h40000 gives 32'hFFFC_0000; 19'h3FFFF gives 32'h0003_FFFF.
- BAOUT_R0_ZERO_EN defined: mode 3 with Rb=0 -> baseZero=1 only in RD_B. Mode 2 with Rb=0 -> baseZero=0.
